spi_device_byte: RTL

- SPI responder (device end) for the demo system's SPI host port. Used in on-board loopback, test harnesses and a second-FPGA peripheral role.
- Oversamples SCK, CS_N and SDI in the system clock domain; fixed mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames.
- Presents received bytes and accepts bytes to transmit over valid/ready interfaces toward a bus-attached register block.

---
 rtl/spi_device_pkg.sv | 12 +
 rtl/spi_sync_ff.sv | 25 ++
 rtl/spi_device_byte.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/spi_device_pkg.sv
// Shared types and sizes for the SPI device byte responder.
package spi_device_pkg;

    localparam int unsigned SpiFrameBits = 8;
    localparam int unsigned BitCntW      = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/spi_sync_ff.sv
// Multi-stage synchroniser for one asynchronous input bit with selectable reset value.
module spi_sync_ff #(
    parameter int unsigned Stages = 2,
    parameter logic        RstVal = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [Stages-1:0] chain;

    // Shift the pin value through the flop chain toward q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {Stages{RstVal}};
        end else begin
            chain <= {chain[Stages-2:0], d};
        end
    end

    assign q = chain[Stages-1];

endmodule

// File: rtl/spi_device_byte.sv
// SPI mode-0 device: oversampled SCK/CS/SDI, 8-bit MSB-first frames, valid/ready byte interfaces.
module spi_device_byte
    import spi_device_pkg::*;
#(
    parameter int unsigned SyncStages = 2,
    parameter logic [7:0]  TxIdleByte = 8'hFF
) (
    input  logic       clk_sys_i,
    input  logic       rst_sys_ni,
    input  logic       spi_sck_i,
    input  logic       spi_cs_ni,
    input  logic       spi_sdi_i,
    output logic       spi_sdo_o,
    output logic       spi_sdo_en_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       rx_overflow_o,
    output logic       tx_underrun_o,
    output logic       active_o
);

    logic sck_s, cs_s, sdi_s;
    logic sck_q, cs_q;
    logic sck_rise, sck_fall, cs_fall, cs_rise;

    state_e                  state_q, state_d;
    logic [BitCntW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [SpiFrameBits-1:0] tx_shift_q, tx_shift_d;
    logic [SpiFrameBits-1:0] rx_shift_q, rx_shift_d;
    logic [SpiFrameBits-1:0] hold_q, hold_d;
    logic [SpiFrameBits-1:0] rx_data_q, rx_data_d;
    logic [SpiFrameBits-1:0] next_byte;
    logic [SpiFrameBits-1:0] rx_assembled;
    logic tx_ready_q, tx_ready_d;
    logic sdo_q, sdo_d;
    logic sdo_en_q, sdo_en_d;
    logic active_q, active_d;
    logic rx_valid_q, rx_valid_d;
    logic ovf_q, ovf_d;
    logic undr_q, undr_d;

    spi_sync_ff #(.Stages(SyncStages), .RstVal(1'b0)) u_sync_sck (
        .clk(clk_sys_i), .rst_n(rst_sys_ni), .d(spi_sck_i), .q(sck_s)
    );
    spi_sync_ff #(.Stages(SyncStages), .RstVal(1'b1)) u_sync_cs (
        .clk(clk_sys_i), .rst_n(rst_sys_ni), .d(spi_cs_ni), .q(cs_s)
    );
    spi_sync_ff #(.Stages(SyncStages), .RstVal(1'b0)) u_sync_sdi (
        .clk(clk_sys_i), .rst_n(rst_sys_ni), .d(spi_sdi_i), .q(sdi_s)
    );

    assign sck_rise = sck_s & ~sck_q;
    assign sck_fall = ~sck_s & sck_q;
    assign cs_fall  = ~cs_s & cs_q;
    assign cs_rise  = cs_s & ~cs_q;

    // Byte offered at a byte start: held byte if present, else the idle filler.
    assign next_byte    = tx_ready_q ? TxIdleByte : hold_q;
    assign rx_assembled = {rx_shift_q[SpiFrameBits-2:0], sdi_s};

    // State, edge-detect and datapath registers.
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            sck_q      <= 1'b0;
            cs_q       <= 1'b1;
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            hold_q     <= '0;
            tx_ready_q <= 1'b1;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            sdo_q      <= 1'b0;
            sdo_en_q   <= 1'b0;
            active_q   <= 1'b0;
            ovf_q      <= 1'b0;
            undr_q     <= 1'b0;
        end else begin
            sck_q      <= sck_s;
            cs_q       <= cs_s;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            hold_q     <= hold_d;
            tx_ready_q <= tx_ready_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            sdo_q      <= sdo_d;
            sdo_en_q   <= sdo_en_d;
            active_q   <= active_d;
            ovf_q      <= ovf_d;
            undr_q     <= undr_d;
        end
    end

    // Next-state and next-output logic; CS events take priority over SCK edges.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        hold_d     = hold_q;
        tx_ready_d = tx_ready_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        sdo_d      = sdo_q;
        sdo_en_d   = sdo_en_q;
        active_d   = active_q;
        ovf_d      = 1'b0;
        undr_d     = 1'b0;

        if (tx_valid_i && tx_ready_q) begin
            hold_d     = tx_data_i;
            tx_ready_d = 1'b0;
        end

        if (rx_valid_q && rx_ready_i) begin
            rx_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d    = SHIFT;
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                    tx_shift_d = next_byte;
                    sdo_d      = next_byte[SpiFrameBits-1];
                    sdo_en_d   = 1'b1;
                    active_d   = 1'b1;
                    if (tx_ready_q) begin
                        undr_d = 1'b1;
                    end else begin
                        tx_ready_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    sdo_d     = 1'b0;
                    sdo_en_d  = 1'b0;
                    active_d  = 1'b0;
                end else if (sck_rise) begin
                    rx_shift_d = rx_assembled;
                    bit_cnt_d  = bit_cnt_q + BitCntW'(1);
                    if (bit_cnt_q == BitCntW'(SpiFrameBits - 1)) begin
                        if (rx_valid_q && !rx_ready_i) begin
                            ovf_d = 1'b1;
                        end else begin
                            rx_data_d  = rx_assembled;
                            rx_valid_d = 1'b1;
                        end
                    end
                end else if (sck_fall) begin
                    if (bit_cnt_q != '0) begin
                        tx_shift_d = {tx_shift_q[SpiFrameBits-2:0], 1'b0};
                        sdo_d      = tx_shift_q[SpiFrameBits-2];
                    end else begin
                        tx_shift_d = next_byte;
                        sdo_d      = next_byte[SpiFrameBits-1];
                        if (tx_ready_q) begin
                            undr_d = 1'b1;
                        end else begin
                            tx_ready_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign spi_sdo_o     = sdo_q;
    assign spi_sdo_en_o  = sdo_en_q;
    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;
    assign tx_ready_o    = tx_ready_q;
    assign rx_overflow_o = ovf_q;
    assign tx_underrun_o = undr_q;
    assign active_o      = active_q;

endmodule
